window_fetch_ctrl: RTL
======================

// Module: window_fetch_ctrl
// PURPOSE
// - Control FSM directly upstream of the 3x3-window display datapath. Drives that datapath's counter, load and select strobes.
// - Per interior pixel: fetch 9 neighbours from image ROM in tap order, load the window registers, pulse plot, advance x/y.
// - Sweeps the full frame x=1..158, y=1..118, then pulses done and returns to idle.
// PARAMETERS
// - MEM_LAT   1   image ROM read latency in cycles, >=1; pixel_in valid MEM_LAT cycles after sel_address/sel_im change
// - NTAPS     9   window taps, fixed at 9; sel_address k=0..8 row-major, (x-1,y-1)..(x+1,y+1)
// PORTS
// - clock        in   1  system clock
// - resetn       in   1  synchronous, active-low reset
// - start        in   1  begin frame; sampled only in IDLE
// - img_sel      in   3  ROM image select; latched on accepted start
// - row_done     in   1  registered flag from datapath x counter; valid the cycle after rowCountEn
// - col_done     in   1  registered flag from datapath y counter; valid the cycle after colCountEn
// - rowCountEn   out  1  advance x by one
// - colCountEn   out  1  advance y by one
// - reset_sig_x  out  1  force x=1
// - reset_sig_y  out  1  force y=1
// - ld           out  9  one-hot window-register load; ld[k] drives ld_k
// - sel_address  out  4  current tap index 0..8
// - sel_im       out  3  latched img_sel
// - plot         out  1  colour_out/x/y valid for write
// - busy         out  1  high from accepted start until done
// - done         out  1  one-cycle pulse after last pixel
// BEHAVIOUR
// - Reset: state=IDLE, k=0, w=0. All outputs 0, including sel_address and sel_im.
// - Outputs are Moore, decoded from state/k/w; they change only on clock edges.
// - IDLE: start=1 -> CLEAR; latch img_sel; busy=1 from the next cycle.
// - CLEAR (1 cycle): reset_sig_x=reset_sig_y=1; k=0, w=0 -> FETCH.
// - FETCH: sel_address=k; w counts 0..MEM_LAT.
//   - When w==MEM_LAT: ld[k]=1 that cycle, w=0.
//   - If k==8 -> PLOT, otherwise k++.
//   - Each tap takes MEM_LAT+1 cycles; sel_address is stable the whole time.
// - PLOT (1 cycle): plot=1. Window registers were loaded the previous edge, so datapath output is valid.
// - ADV_X (1 cycle): rowCountEn=1 -> CHK_X.
// - CHK_X: row_done=1 -> ADV_Y; else k=0 -> FETCH.
//   - row_done stays high until the next rowCountEn; CHK_X is the only state that samples it.
// - ADV_Y (1 cycle): colCountEn=1 -> CHK_Y. x has already wrapped to 1 in the datapath.
// - CHK_Y: col_done=1 -> DONE; else k=0 -> FETCH.
// - DONE (1 cycle): done=1, busy=0 -> IDLE.
// - Mutual exclusion: at most one of ld bits, plot, rowCountEn, colCountEn is high in any cycle; ld never asserted outside FETCH.
// - start while busy: ignored. start held high at DONE: a new frame begins on the IDLE cycle after DONE.
// - resetn low mid-frame: abort on the next edge to IDLE with outputs 0. Partial frame is discarded; no done pulse.
// - Timing:
//   - Pixel period = 9*(MEM_LAT+1)+3 cycles; add 2 at row end.
//   - Frame = 158*118 plots.
//   - MEM_LAT=1: 21 cycles/pixel; total = 2 + 18644*21 + 118*2 + 1 cycles from start to done, inclusive of CLEAR and DONE.
// - Widths: k 4 bits, w $clog2(MEM_LAT+1) bits; no arithmetic overflow possible.
// STRUCTURE
// - Shared package display_pkg:
//   - state encoding: IDLE, CLEAR, FETCH, PLOT, ADV_X, CHK_X, ADV_Y, CHK_Y, DONE
//   - constants: X_MIN=1, X_MAX=158, Y_MIN=1, Y_MAX=118, NTAPS=9
//   - tap-index-to-offset table, shared with address_adaptor
// - Sub-module tap_sequencer: k/w counters, ld one-hot decode and last_tap flag. The top holds the FSM only.
// TESTING
// - Reset then start=1, img_sel=3'd5, MEM_LAT=1: CLEAR one cycle; sel_address steps 0..8, 2 cycles each.
//   - ld[k] fires on the second cycle of each tap; plot fires 1 cycle after ld[8]; sel_im=5 throughout.
// - Datapath model bound, full frame: exactly 18644 plot pulses and 118 colCountEn pulses.
//   - Single done pulse, at cycle count per the timing formula; busy low after.
// - MEM_LAT=3: each sel_address value held 4 cycles; ld[k] on the 4th; pixel period 39 cycles.
// - start pulsed mid-frame: no effect on sequence or counts.
// - resetn low during FETCH, k=4: next cycle all outputs 0 and state IDLE.
//   - A new start then yields CLEAR with reset_sig_x/y=1 and sel_address=0.
// - Assertions every cycle: $onehot0({ld,plot,rowCountEn,colCountEn}).
//   - No ld outside FETCH; done implies !busy on the next cycle.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the 3x3-window display path: controller states,
// frame bounds and the tap-index-to-neighbour-offset table.
package display_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        FETCH,
        PLOT,
        ADV_X,
        CHK_X,
        ADV_Y,
        CHK_Y,
        DONE
    } state_t;

    localparam int unsigned X_MIN = 1;
    localparam int unsigned X_MAX = 158;
    localparam int unsigned Y_MIN = 1;
    localparam int unsigned Y_MAX = 118;
    localparam int unsigned NTAPS = 9;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } tap_ofs_t;

    // Row-major neighbour offset for tap k: k=0 -> (-1,-1) ... k=8 -> (+1,+1).
    function automatic tap_ofs_t tap_offset(input logic [3:0] k);
        tap_ofs_t   ofs;
        logic [3:0] col;
        logic [3:0] row;
        col    = k % 4'd3;
        row    = k / 4'd3;
        ofs.dx = 2'(col[1:0] - 2'd1);
        ofs.dy = 2'(row[1:0] - 2'd1);
        return ofs;
    endfunction

endpackage

// File: rtl/tap_sequencer.sv
// Tap and ROM-latency counters for the window fetch: walks k over the taps,
// holding each for MEM_LAT+1 cycles, and decodes the one-hot load strobe.
module tap_sequencer #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned NTAPS   = 9
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             i_run,
    output logic [3:0]       o_k,
    output logic [NTAPS-1:0] o_ld,
    output logic             o_last_tap
);
    import display_pkg::*;

    localparam int unsigned   WW     = $clog2(MEM_LAT + 1);
    localparam logic [WW-1:0] W_LAST = WW'(MEM_LAT);
    localparam logic [3:0]    K_LAST = 4'(NTAPS - 1);

    logic [3:0]    r_k;
    logic [WW-1:0] r_w;
    logic          w_fire;

    assign w_fire = i_run && (r_w == W_LAST);

    // Counters idle at zero outside the fetch so every fetch starts at tap 0.
    always_ff @(posedge clock) begin
        if (!resetn || !i_run) begin
            r_k <= '0;
            r_w <= '0;
        end else if (w_fire) begin
            r_w <= '0;
            r_k <= (r_k == K_LAST) ? '0 : r_k + 4'd1;
        end else begin
            r_w <= r_w + WW'(1);
        end
    end

    // Load strobe for the current tap on the cycle its ROM data is valid.
    always_comb begin
        o_ld = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            o_ld[i] = w_fire && (r_k == 4'(i));
        end
    end

    assign o_k        = r_k;
    assign o_last_tap = w_fire && (r_k == K_LAST);

endmodule

// File: rtl/window_fetch_ctrl.sv
// Frame-sweep controller for the 3x3-window display datapath: per interior
// pixel fetches nine taps, plots, then advances the datapath x/y counters.
module window_fetch_ctrl #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned NTAPS   = 9
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       img_sel,
    input  logic             row_done,
    input  logic             col_done,
    output logic             rowCountEn,
    output logic             colCountEn,
    output logic             reset_sig_x,
    output logic             reset_sig_y,
    output logic [NTAPS-1:0] ld,
    output logic [3:0]       sel_address,
    output logic [2:0]       sel_im,
    output logic             plot,
    output logic             busy,
    output logic             done
);
    import display_pkg::*;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_sel_im;
    logic [3:0]       w_k;
    logic [NTAPS-1:0] w_ld;
    logic             w_last_tap;
    logic             w_run;

    assign w_run = (r_state == FETCH);

    tap_sequencer #(
        .MEM_LAT (MEM_LAT),
        .NTAPS   (NTAPS)
    ) u_taps (
        .clock      (clock),
        .resetn     (resetn),
        .i_run      (w_run),
        .o_k        (w_k),
        .o_ld       (w_ld),
        .o_last_tap (w_last_tap)
    );

    // State register and image select captured on an accepted start.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_sel_im <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_sel_im <= img_sel;
            end
        end
    end

    // Next-state: tap fetch, plot, then x advance with row/column end checks.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLEAR;
            CLEAR:   w_next = FETCH;
            FETCH:   if (w_last_tap) w_next = PLOT;
            PLOT:    w_next = ADV_X;
            ADV_X:   w_next = CHK_X;
            CHK_X:   w_next = row_done ? ADV_Y : FETCH;
            ADV_Y:   w_next = CHK_Y;
            CHK_Y:   w_next = col_done ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore strobes decoded from the registered state.
    always_comb begin
        rowCountEn  = 1'b0;
        colCountEn  = 1'b0;
        reset_sig_x = 1'b0;
        reset_sig_y = 1'b0;
        plot        = 1'b0;
        done        = 1'b0;
        case (r_state)
            CLEAR: begin
                reset_sig_x = 1'b1;
                reset_sig_y = 1'b1;
            end
            PLOT:    plot       = 1'b1;
            ADV_X:   rowCountEn = 1'b1;
            ADV_Y:   colCountEn = 1'b1;
            DONE:    done       = 1'b1;
            default: ;
        endcase
        busy = (r_state != IDLE) && (r_state != DONE);
    end

    // The tap counter rests at zero outside FETCH, so it can drive the ROM
    // address directly.
    assign sel_address = w_k;
    assign ld          = w_ld;
    assign sel_im      = r_sel_im;

endmodule
